// File: rtl/key_step_debounce.sv
// Push-button debouncer producing the single-step clock (rclk), press/release strobes and a press counter.
// Optional auto-repeat while the key is held is enabled by defining AUTO_REPEAT_EN.
module key_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_W           = 21,
  parameter int unsigned PRESS_CNT_W     = 8,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic                   oclk,
  output logic                   rclk,
  output logic                   step_pulse,
  output logic                   release_pulse,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_PRESSED      = 3'd2;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd3;
`ifdef AUTO_REPEAT_EN
  localparam logic [2:0] S_REPEAT_GAP   = 3'd4;
`endif

  localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]       DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRESS_CNT_W-1:0] PC_ONE  = PRESS_CNT_W'(1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0]       RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]       RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic [1:0]             sync_q;
  logic                   key_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   rclk_q, rclk_d;
  logic                   step_q, step_d;
  logic                   rel_q, rel_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
`ifdef AUTO_REPEAT_EN
  logic                   rpt_q, rpt_d;
  logic [CNT_W-1:0]       rpt_limit;
`endif

  assign key_s   = sync_q[1];
  assign cnt_inc = cnt_q + CNT_ONE;
`ifdef AUTO_REPEAT_EN
  // The first repeat waits the long hold delay; later ones use the shorter period.
  assign rpt_limit = rpt_q ? RPT_NEXT : RPT_FIRST;
`endif

  // The state is entered on the first sample of the new level, so that sample counts
  // toward the debounce window: a level is accepted once cnt reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rclk_d      = rclk_q;
    step_d      = 1'b0;
    rel_d       = 1'b0;
    press_cnt_d = press_cnt_q;
`ifdef AUTO_REPEAT_EN
    rpt_d       = rpt_q;
`endif

    case (state_q)
      S_IDLE: begin
        rclk_d = 1'b0;
        if (key_s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      S_PRESS_WAIT: begin
        if (!key_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DB_LAST) begin
          state_d     = S_PRESSED;
          cnt_d       = '0;
          rclk_d      = 1'b1;
          step_d      = 1'b1;
          press_cnt_d = press_cnt_q + PC_ONE;
`ifdef AUTO_REPEAT_EN
          rpt_d       = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_PRESSED: begin
        rclk_d = 1'b1;
        if (!key_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
          rpt_d   = 1'b0;
        end else if (cnt_inc == rpt_limit) begin
          state_d = S_REPEAT_GAP;
          cnt_d   = '0;
          rclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end

      S_RELEASE_WAIT: begin
        rclk_d = 1'b1;
        if (key_s) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == DB_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rclk_d  = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

`ifdef AUTO_REPEAT_EN
      // Always completes the repeat edge, even if the key is already released.
      S_REPEAT_GAP: begin
        state_d     = S_PRESSED;
        cnt_d       = '0;
        rclk_d      = 1'b1;
        step_d      = 1'b1;
        press_cnt_d = press_cnt_q + PC_ONE;
        rpt_d       = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rclk_q      <= 1'b0;
      step_q      <= 1'b0;
      rel_q       <= 1'b0;
      press_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
      rpt_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep the two synchronizer stages distinct registers.
      sync_q      <= {sync_q[0], oclk};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rclk_q      <= rclk_d;
      step_q      <= step_d;
      rel_q       <= rel_d;
      press_cnt_q <= press_cnt_d;
`ifdef AUTO_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign rclk          = rclk_q;
  assign step_pulse    = step_q;
  assign release_pulse = rel_q;
  assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed bench for key_step_debounce with short sim parameters (debounce 8, repeat 12/6).
// Expected values follow the AUTO_REPEAT_EN setting of the build.
module tb_key_step_debounce;

  localparam int DB  = 8;
  localparam int CW  = 4;
  localparam int PCW = 8;
  localparam int RD  = 12;
  localparam int RP  = 6;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  // Held short enough with repeat enabled that test 1 never reaches the first repeat.
  localparam int HOLD1 = AR ? 16 : 20;

  logic           clk_100MHz = 1'b0;
  logic           rst;
  logic           oclk;
  logic           rclk;
  logic           step_pulse;
  logic           release_pulse;
  logic [PCW-1:0] press_cnt;

  int       n_cmp = 0;
  int       n_bad = 0;
  logic [7:0] exp_pc;

  key_step_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .PRESS_CNT_W    (PCW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .oclk         (oclk),
    .rclk         (rclk),
    .step_pulse   (step_pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    oclk = 1'b0;
    #12;
    n_cmp++;
    if ({rclk, step_pulse, release_pulse, press_cnt} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", {rclk, step_pulse, release_pulse, press_cnt}, 11'b0);
    end
    #4 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({rclk, step_pulse, release_pulse, press_cnt} !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_after tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse, press_cnt}, 11'b0);
      end
    end
    exp_pc = 8'd0;
  endtask

  task automatic test_press_release();
    logic [2:0] e;
    oclk = 1'b1;
    for (int i = 1; i <= HOLD1; i++) begin
      tick();
      e = {i >= 10, i == 10, 1'b0};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL press tick %0d: got rclk/step/rel=%b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    exp_pc = exp_pc + 8'd1;
    oclk = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = {i < 10, 1'b0, i == 10};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL release tick %0d: got rclk/step/rel=%b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    n_cmp++;
    if (press_cnt !== exp_pc) begin
      n_bad++;
      $display("FAIL press_cnt_single: got %0d want %0d", press_cnt, exp_pc);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] e;
    for (int b = 0; b < 30; b++) begin
      oclk = ((b / 3) % 2) == 0;
      tick();
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== 3'b000) begin
        n_bad++;
        $display("FAIL bounce tick %0d: got rclk/step/rel=%b want 000", b, {rclk, step_pulse, release_pulse});
      end
    end
    oclk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = {i >= 10, i == 10, 1'b0};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL bounce_settle tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    exp_pc = exp_pc + 8'd1;
    n_cmp++;
    if (press_cnt !== exp_pc) begin
      n_bad++;
      $display("FAIL bounce_press_cnt: got %0d want %0d", press_cnt, exp_pc);
    end
    oclk = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = {i < 10, 1'b0, i == 10};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL bounce_release tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
  endtask

  task automatic test_wrap();
    int n_step = 0;
    int n_rel  = 0;
    int n_both = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_pc = 8'd0;
    for (int k = 0; k < 256; k++) begin
      oclk = 1'b1;
      for (int i = 0; i < 12; i++) begin
        tick();
        n_step += int'(step_pulse);
        n_rel  += int'(release_pulse);
        n_both += int'(step_pulse & release_pulse);
      end
      oclk = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        n_step += int'(step_pulse);
        n_rel  += int'(release_pulse);
        n_both += int'(step_pulse & release_pulse);
      end
      exp_pc = exp_pc + 8'd1;
      n_cmp++;
      if (press_cnt !== exp_pc) begin
        n_bad++;
        $display("FAIL wrap_press_cnt press %0d: got %0d want %0d", k, press_cnt, exp_pc);
      end
    end
    n_cmp++;
    if (press_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL wrap_final: got %h want 00", press_cnt);
    end
    n_cmp++;
    if (n_step != 256) begin
      n_bad++;
      $display("FAIL wrap_steps: got %0d want 256", n_step);
    end
    n_cmp++;
    if (n_rel != 256) begin
      n_bad++;
      $display("FAIL wrap_releases: got %0d want 256", n_rel);
    end
    n_cmp++;
    if (n_both != 0) begin
      n_bad++;
      $display("FAIL wrap_overlap: got %0d want 0", n_both);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] e;
    oclk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = {i >= 10, i == 10, 1'b0};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL glitch_press tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    exp_pc = exp_pc + 8'd1;
    oclk = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) oclk = 1'b1;
      tick();
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== 3'b100) begin
        n_bad++;
        $display("FAIL glitch_hold tick %0d: got %b want 100", i, {rclk, step_pulse, release_pulse});
      end
    end
    oclk = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = {i < 10, 1'b0, i == 10};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL glitch_release tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    n_cmp++;
    if (press_cnt !== exp_pc) begin
      n_bad++;
      $display("FAIL glitch_press_cnt: got %0d want %0d", press_cnt, exp_pc);
    end
  endtask

  task automatic test_async_reset();
    oclk = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== 3'b000) begin
        n_bad++;
        $display("FAIL areset_wait tick %0d: got %b want 000", i, {rclk, step_pulse, release_pulse});
      end
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rclk, step_pulse, release_pulse, press_cnt} !== 11'b0) begin
      n_bad++;
      $display("FAIL areset_immediate: got %b want %b", {rclk, step_pulse, release_pulse, press_cnt}, 11'b0);
    end
    oclk = 1'b0;
    #2 rst = 1'b0;
    exp_pc = 8'd0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++;
      if ({rclk, step_pulse, release_pulse, press_cnt} !== 11'b0) begin
        n_bad++;
        $display("FAIL areset_after tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse, press_cnt}, 11'b0);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [2:0] e;
    logic       er, es;
    oclk = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (AR) begin
        er = (i >= 10) && !(i == 21 || i == 27 || i == 33 || i == 39);
        es = (i == 10 || i == 22 || i == 28 || i == 34 || i == 40);
      end else begin
        er = (i >= 10);
        es = (i == 10);
      end
      e = {er, es, 1'b0};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL repeat_hold tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
    exp_pc = AR ? 8'd5 : 8'd1;
    n_cmp++;
    if (press_cnt !== exp_pc) begin
      n_bad++;
      $display("FAIL repeat_press_cnt: got %0d want %0d", press_cnt, exp_pc);
    end
    oclk = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      e = {i < 10, 1'b0, i == 10};
      n_cmp++;
      if ({rclk, step_pulse, release_pulse} !== e) begin
        n_bad++;
        $display("FAIL repeat_release tick %0d: got %b want %b", i, {rclk, step_pulse, release_pulse}, e);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    oclk   = 1'b0;
    exp_pc = 8'd0;
    test_reset();
    test_press_release();
    test_bounce();
    test_wrap();
    test_glitch();
    test_async_reset();
    test_auto_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
